nms_stream_core: RTL and testbench

NMS_STREAM_CORE -- requirements
Module: nms_stream_core

---
 rtl/canny_pkg.sv | 28 ++
 rtl/nms_dir_select.sv | 50 +++++
 rtl/nms_stream_core.sv | 208 ++++++++++++++++++++
 tb/tb_nms_stream_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// canny_pkg: definitions shared by the Canny edge-detection pipeline blocks.
//   - direction codes carried in the two MSBs of every window tap
//   - edge classification codes driven on out_class
//   - state encoding for the non-maximum-suppression stream controller
//   - window geometry (tap count, centre tap index)
package canny_pkg;

  localparam logic [1:0] DIR_N  = 2'b00;
  localparam logic [1:0] DIR_E  = 2'b01;
  localparam logic [1:0] DIR_NW = 2'b10;
  localparam logic [1:0] DIR_NE = 2'b11;

  localparam logic [1:0] CLS_NONE   = 2'b00;
  localparam logic [1:0] CLS_WEAK   = 2'b01;
  localparam logic [1:0] CLS_STRONG = 2'b10;

  // Window taps are numbered p11..p33 row-major; tap 0 sits in the LSBs.
  localparam int unsigned WIN_TAPS   = 9;
  localparam int unsigned CENTER_TAP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } nms_state_t;

endpackage

// File: rtl/nms_dir_select.sv
// nms_dir_select: combinational neighbour mux for non-maximum suppression.
// Picks the two magnitudes lying along the gradient direction of the
// centre tap p22.
//   win        : 9 taps p11..p33 (p11 in LSBs), each {dir[1:0], mag}
//   center_mag : magnitude of p22
//   nbr_a      : first neighbour  (N:p12  E:p21  NW:p11  NE:p13)
//   nbr_b      : second neighbour (N:p32  E:p23  NW:p33  NE:p31)
module nms_dir_select
  import canny_pkg::*;
#(
  parameter int MAG_WIDTH = 24
) (
  input  logic [WIN_TAPS*(MAG_WIDTH+2)-1:0] win,
  output logic [MAG_WIDTH-1:0]              center_mag,
  output logic [MAG_WIDTH-1:0]              nbr_a,
  output logic [MAG_WIDTH-1:0]              nbr_b
);

  localparam int unsigned EW = MAG_WIDTH + 2;

  logic [MAG_WIDTH-1:0] mag [WIN_TAPS];
  logic [1:0]           center_dir;
  // Direction fields of the eight surrounding taps carry no meaning here.
  logic                 unused_nbr_dirs;

  always_comb begin
    unused_nbr_dirs = 1'b0;
    for (int unsigned i = 0; i < WIN_TAPS; i++) begin
      mag[i] = win[i*EW +: MAG_WIDTH];
      if (i != CENTER_TAP) begin
        unused_nbr_dirs = unused_nbr_dirs ^ (^win[i*EW+MAG_WIDTH +: 2]);
      end
    end
  end

  assign center_dir = win[CENTER_TAP*EW+MAG_WIDTH +: 2];
  assign center_mag = mag[CENTER_TAP];

  always_comb begin
    nbr_a = mag[2];
    nbr_b = mag[6];
    case (center_dir)
      DIR_N:   begin nbr_a = mag[1]; nbr_b = mag[7]; end
      DIR_E:   begin nbr_a = mag[3]; nbr_b = mag[5]; end
      DIR_NW:  begin nbr_a = mag[0]; nbr_b = mag[8]; end
      default: begin nbr_a = mag[2]; nbr_b = mag[6]; end
    endcase
  end

endmodule

// File: rtl/nms_stream_core.sv
// nms_stream_core: streaming non-maximum suppression with optional
// hysteresis classification over one IMG_WIDTH x IMG_HEIGHT frame.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : frame enable, held high for the whole frame
//   in_valid/in_ready   : window handshake
//   in_win              : 3x3 window, {dir, mag} per tap, p11 in LSBs
//   low_thr, high_thr   : hysteresis thresholds
//   out_valid/out_ready : output handshake
//   out_mag, out_class  : suppressed magnitude and edge class
//   out_sof, out_eol    : first pixel of frame, last pixel of row
//   frame_done          : one-cycle pulse once the frame has drained
// Build option: define NMS_HYSTERESIS_EN to enable weak/strong classification;
// otherwise out_class is tied to CLS_NONE and the thresholds are ignored.
module nms_stream_core
  import canny_pkg::*;
#(
  parameter int MAG_WIDTH  = 24,
  parameter int IMG_WIDTH  = 634,
  parameter int IMG_HEIGHT = 506
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIN_TAPS*(MAG_WIDTH+2)-1:0] in_win,
  input  logic [MAG_WIDTH-1:0]              low_thr,
  input  logic [MAG_WIDTH-1:0]              high_thr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MAG_WIDTH-1:0]              out_mag,
  output logic [1:0]                        out_class,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              frame_done
);

  localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  nms_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic en;
  logic accept;
  logic abort;
  logic last_px;

  // Stage 1 registers
  logic                 v1;
  logic [MAG_WIDTH-1:0] s1_c;
  logic [MAG_WIDTH-1:0] s1_a;
  logic [MAG_WIDTH-1:0] s1_b;
  logic                 s1_border;
  logic                 s1_sof;
  logic                 s1_eol;

  // Neighbour mux output feeding stage 1
  logic [MAG_WIDTH-1:0] sel_c;
  logic [MAG_WIDTH-1:0] sel_a;
  logic [MAG_WIDTH-1:0] sel_b;

  // Stage 2 combinational result
  logic                 keep;
  logic [MAG_WIDTH-1:0] sup_mag;

  // Both stages share one enable so a stalled output freezes the pipeline.
  assign en       = out_ready | ~out_valid;
  assign in_ready = (state == RUN) & en;
  assign accept   = in_valid & in_ready;
  assign abort    = ~start & ((state == RUN) | (state == DRAIN));
  assign last_px  = (col == COL_LAST) & (row == ROW_LAST);

  nms_dir_select #(
    .MAG_WIDTH(MAG_WIDTH)
  ) u_dir_select (
    .win       (in_win),
    .center_mag(sel_c),
    .nbr_a     (sel_a),
    .nbr_b     (sel_b)
  );

  // Frame controller and pixel position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (!start) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
          end else if (accept) begin
            if (last_px) begin
              state <= DRAIN;
              col   <= '0;
              row   <= '0;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!start) begin
            state <= IDLE;
          end else if (!v1 && !out_valid) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage 2 decision: keep p22 only if it is a local maximum (ties kept).
  assign keep    = (s1_c >= s1_a) && (s1_c >= s1_b);
  assign sup_mag = (s1_border || !keep) ? '0 : s1_c;

  // Two-stage data pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_c      <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_border <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (abort) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1 <= accept;
      if (accept) begin
        s1_c      <= sel_c;
        s1_a      <= sel_a;
        s1_b      <= sel_b;
        s1_border <= (row == '0) || (row == ROW_LAST) ||
                     (col == '0) || (col == COL_LAST);
        s1_sof    <= (row == '0) && (col == '0);
        s1_eol    <= (col == COL_LAST);
      end
      out_valid <= v1;
      if (v1) begin
        out_mag <= sup_mag;
        out_sof <= s1_sof;
        out_eol <= s1_eol;
      end
    end
  end

`ifdef NMS_HYSTERESIS_EN
  logic [1:0] sup_cls;

  // A zero magnitude is never an edge, even with a zero threshold. With
  // low_thr > high_thr anything reaching low_thr is already strong, so the
  // weak band empties without extra logic.
  always_comb begin
    sup_cls = CLS_NONE;
    if (sup_mag != '0) begin
      if (sup_mag >= high_thr) begin
        sup_cls = CLS_STRONG;
      end else if (sup_mag >= low_thr) begin
        sup_cls = CLS_WEAK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_class <= CLS_NONE;
    end else if (!abort && en && v1) begin
      out_class <= sup_cls;
    end
  end
`else
  logic unused_thr;

  assign unused_thr = ^{low_thr, high_thr};
  assign out_class  = CLS_NONE;
`endif

endmodule

// File: tb/tb_nms_stream_core.sv
module tb_nms_stream_core;

  localparam int MW   = 24;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int N    = W * H;
  localparam int EW   = MW + 2;
  localparam int WINW = 9 * EW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [WINW-1:0] in_win;
  logic [MW-1:0]   low_thr;
  logic [MW-1:0]   high_thr;
  logic            out_valid;
  logic            out_ready;
  logic [MW-1:0]   out_mag;
  logic [1:0]      out_class;
  logic            out_sof;
  logic            out_eol;
  logic            frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nms_stream_core #(
    .MAG_WIDTH (MW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_win    (in_win),
    .low_thr   (low_thr),
    .high_thr  (high_thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_class (out_class),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window for raster pixel k. Non-neighbour taps hold the maximum value so a
  // wrong neighbour choice suppresses the pixel.
  function automatic logic [WINW-1:0] mk_win(input int k);
    logic [1:0]      d;
    logic [MW-1:0]   c, na, nb;
    int              ia, ib;
    logic [WINW-1:0] w;
    case (k)
      6:       begin d = 2'd0; c = 100; na = 99; nb = 100; end
      7:       begin d = 2'd3; c = 40;  na = 41; nb = 0;   end
      8:       begin d = 2'd3; c = 60;  na = 10; nb = 10;  end
      11:      begin d = 2'd1; c = 89;  na = 89; nb = 89;  end
      12:      begin d = 2'd2; c = 90;  na = 5;  nb = 91;  end
      13:      begin d = 2'd2; c = 90;  na = 0;  nb = 0;   end
      default: begin d = 2'(k % 4); c = 200; na = 0; nb = 0; end
    endcase
    case (d)
      2'd0:    begin ia = 1; ib = 7; end
      2'd1:    begin ia = 3; ib = 5; end
      2'd2:    begin ia = 0; ib = 8; end
      default: begin ia = 2; ib = 6; end
    endcase
    for (int i = 0; i < 9; i++) w[i*EW +: EW] = {2'(i % 4), {MW{1'b1}}};
    w[ia*EW +: MW] = na;
    w[ib*EW +: MW] = nb;
    w[4*EW +: EW]  = {d, c};
    return w;
  endfunction

  function automatic logic [MW-1:0] exp_mag(input int k);
    case (k)
      6:       return 100;
      8:       return 60;
      11:      return 89;
      13:      return 90;
      default: return 0;
    endcase
  endfunction

  // mode 0: low=50 high=90, mode 1: low=0 high=95, mode 2: low=100 high=60
  function automatic logic [1:0] exp_cls(input int k, input int mode);
`ifdef NMS_HYSTERESIS_EN
    case (k)
      6:       return 2'b10;
      8:       return (mode == 2) ? 2'b10 : 2'b01;
      11:      return (mode == 2) ? 2'b10 : 2'b01;
      13:      return (mode == 1) ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
`else
    return (k < 0) ? 2'b11 : 2'b00;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_out_mag"},    out_mag,    0);
    check({tag, "_out_class"},  out_class,  0);
    check({tag, "_out_sof"},    out_sof,    0);
    check({tag, "_out_eol"},    out_eol,    0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_in_ready"},   in_ready,   0);
  endtask

  // Streams one frame. cut_at > 0 stops after that many accepts, either by
  // dropping start (cut_rst=0) or by asserting reset (cut_rst=1).
  task automatic run_frame(input int mode, input bit stall, input int cut_at, input bit cut_rst);
    int ip = 0, ob = 0, dones = 0, eols = 0, sofs = 0, post = 0;
    int acc_cyc [N];
    bit held = 0;
    logic [MW-1:0] h_mag;
    logic [1:0]    h_cls;
    logic          h_sof, h_eol;
    case (mode)
      0:       begin low_thr = 50;  high_thr = 90; end
      1:       begin low_thr = 0;   high_thr = 95; end
      default: begin low_thr = 100; high_thr = 60; end
    endcase
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_mag",   out_mag,   h_mag);
        check("hold_class", out_class, h_cls);
        check("hold_sof",   out_sof,   h_sof);
        check("hold_eol",   out_eol,   h_eol);
      end
      if (frame_done) begin
        dones++;
        check("done_after_last_beat", ob, N);
        start = 1'b0;
      end
      if (dones > 0) begin
        post++;
        if (post > 4) break;
      end
      if (cut_at > 0 && ip == cut_at) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!cut_rst) begin
          start = 1'b0;
          @(negedge clk);
          check("abort_in_ready", in_ready, 0);
          check("abort_out_valid", out_valid, 0);
          for (int j = 0; j < 4; j++) begin
            check("abort_no_done", frame_done, 0);
            check("abort_idle_valid", out_valid, 0);
            @(negedge clk);
          end
        end else begin
          rst_n = 1'b0;
          #1;
          check_all_zero("rst_mid");
          @(negedge clk);
          start = 1'b0;
          check_all_zero("rst_hold");
          @(negedge clk);
          rst_n = 1'b1;
        end
        return;
      end
      out_ready = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
      in_valid  = (ip < N);
      if (ip < N) in_win = mk_win(ip);
      #1;
      if (out_valid && out_ready) begin
        if (ob < N) begin
          check($sformatf("mag_px%0d", ob),   out_mag,   exp_mag(ob));
          check($sformatf("class_px%0d", ob), out_class, exp_cls(ob, mode));
          check($sformatf("sof_px%0d", ob),   out_sof,   (ob == 0));
          check($sformatf("eol_px%0d", ob),   out_eol,   (ob % W == W - 1));
          if (!stall) check($sformatf("latency_px%0d", ob), cyc - acc_cyc[ob], 2);
        end else begin
          check("extra_beat", ob, N - 1);
        end
        if (out_eol) eols++;
        if (out_sof) sofs++;
        ob++;
      end
      held  = out_valid && !out_ready;
      h_mag = out_mag;
      h_cls = out_class;
      h_sof = out_sof;
      h_eol = out_eol;
      if (in_valid && in_ready) begin
        acc_cyc[ip] = cyc;
        ip++;
      end
    end
    check("frame_beats", ob, N);
    check("frame_done_pulses", dones, 1);
    check("frame_eol_count", eols, H);
    check("frame_sof_count", sofs, 1);
    check("frame_idle_valid", out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_win    = '0;
    out_ready = 1'b1;
    low_thr   = 50;
    high_thr  = 90;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);

    run_frame(0, 1'b0, 0, 1'b0);
    run_frame(1, 1'b1, 0, 1'b0);
    run_frame(2, 1'b0, 0, 1'b0);
    run_frame(0, 1'b0, 7, 1'b0);
    run_frame(0, 1'b0, 0, 1'b0);
    run_frame(0, 1'b0, 8, 1'b1);
    run_frame(0, 1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
